serial_addsub_unit: RTL and testbench

//  Parametrised digit-serial adder/subtractor. Latches A, B and MODE on START,

---
 rtl/serial_addsub_unit.sv | 135 +++++++++++++
 tb/tb_serial_addsub_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub_unit.sv
// Digit-serial adder/subtractor: one DIGIT-bit slice with a registered carry, LSB first.
// Result, borrow/carry and signed overflow are registered together on the final digit.
module serial_addsub_unit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   sum,
    output logic             busy,
    output logic             done,
    output logic             ovf
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    if (DIGIT == 0) begin : g_digit_check
        $error("DIGIT must be at least 1");
    end else if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_width_check
        $error("WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sa_q, sa_d;
    logic [WIDTH-1:0]  sb_q, sb_d;
    logic [WIDTH-1:0]  r_q, r_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              a_msb_q, a_msb_d;
    logic              b_msb_q, b_msb_d;
    logic [WIDTH:0]    sum_q, sum_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;

    logic [DIGIT:0]       slice;
    logic [WIDTH+DIGIT-1:0] r_cat;
    logic [WIDTH-1:0]     r_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sa_q    <= '0;
            sb_q    <= '0;
            r_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            r_q     <= r_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // The slice result enters at the top of R, so after N digits R holds the full word.
    always_comb begin
        slice   = {1'b0, sa_q[DIGIT-1:0]} + {1'b0, sb_q[DIGIT-1:0]}
                  + {{DIGIT{1'b0}}, carry_q};
        r_cat   = {slice[DIGIT-1:0], r_q} >> DIGIT;
        r_shift = r_cat[WIDTH-1:0];
    end

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        r_d     = r_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    sa_d    = a;
                    sb_d    = mode ? ~b : b;
                    carry_d = mode;
                    cnt_d   = '0;
                    mode_d  = mode;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = mode ? ~b[WIDTH-1] : b[WIDTH-1];
                    state_d = StShift;
                end
            end
            StShift: begin
                sa_d    = sa_q >> DIGIT;
                sb_d    = sb_q >> DIGIT;
                r_d     = r_shift;
                carry_d = slice[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(N - 1)) begin
                    // Subtract reports borrow, the inverse of the final carry-out.
                    sum_d   = {mode_q ? ~slice[DIGIT] : slice[DIGIT], r_shift};
                    ovf_d   = (a_msb_q == b_msb_q) && (r_shift[WIDTH-1] != a_msb_q);
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign sum  = sum_q;
    assign ovf  = ovf_q;
    assign done = done_q;
    assign busy = (state_q == StShift);

endmodule

// File: tb/tb_serial_addsub_unit.sv
// Scoreboard bench for serial_addsub_unit: three instances (8/1, 8/4, 16/2) share a, b, mode.
// Expected results are queued at issue and popped when each instance pulses done.
module tb_serial_addsub_unit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  start;
    logic        mode;
    logic [15:0] a;
    logic [15:0] b;

    logic [8:0]  sum81, sum84;
    logic [16:0] sum162;
    logic        busy81, busy84, busy162;
    logic        done81, done84, done162;
    logic        ovf81, ovf84, ovf162;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int accepted [3];
    int done_cnt [3];

    logic [17:0] exp_q0 [$];
    logic [17:0] exp_q1 [$];
    logic [17:0] exp_q2 [$];

    serial_addsub_unit #(.WIDTH(8), .DIGIT(1)) u_d81 (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .mode(mode), .a(a[7:0]), .b(b[7:0]),
        .sum(sum81), .busy(busy81), .done(done81), .ovf(ovf81)
    );

    serial_addsub_unit #(.WIDTH(8), .DIGIT(4)) u_d84 (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .mode(mode), .a(a[7:0]), .b(b[7:0]),
        .sum(sum84), .busy(busy84), .done(done84), .ovf(ovf84)
    );

    serial_addsub_unit #(.WIDTH(16), .DIGIT(2)) u_d162 (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .mode(mode), .a(a), .b(b),
        .sum(sum162), .busy(busy162), .done(done162), .ovf(ovf162)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
        end
    endtask

    // Reference: {ovf, sum} from integer arithmetic and signed range limits.
    function automatic logic [17:0] model(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input logic md);
        longint one  = 1;
        longint mask = (one << w) - 1;
        longint half = one << (w - 1);
        longint x    = longint'(av) & mask;
        longint y    = longint'(bv) & mask;
        longint s, sx, sy, r;
        logic   o;
        if (!md) begin
            s = x + y;
        end else begin
            s = (x - y) & mask;
            if (x < y) s = s | (one << w);
        end
        sx = (x >= half) ? x - (one << w) : x;
        sy = (y >= half) ? y - (one << w) : y;
        r  = md ? sx - sy : sx + sy;
        o  = (r >= half) || (r < -half);
        return {o, s[16:0]};
    endfunction

    function automatic logic [16:0] sum_of(input int sel);
        case (sel)
            0:       return {8'd0, sum81};
            1:       return {8'd0, sum84};
            default: return sum162;
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            0:       return done81;
            1:       return done84;
            default: return done162;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            0:       return busy81;
            1:       return busy84;
            default: return busy162;
        endcase
    endfunction

    task automatic push(input int sel, input logic [15:0] av, input logic [15:0] bv,
                        input logic md);
        case (sel)
            0:       exp_q0.push_back(model(8, av, bv, md));
            1:       exp_q1.push_back(model(8, av, bv, md));
            default: exp_q2.push_back(model(16, av, bv, md));
        endcase
        accepted[sel]++;
    endtask

    task automatic score(input int sel, input logic [16:0] s, input logic o);
        logic [17:0] e;
        int          n;
        string       nm;
        done_cnt[sel]++;
        case (sel)
            0:       n = exp_q0.size();
            1:       n = exp_q1.size();
            default: n = exp_q2.size();
        endcase
        nm = $sformatf("d%0d", sel);
        if (n == 0) begin
            check({nm, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            case (sel)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            check({nm, "_sb_sum"}, {15'd0, s}, {15'd0, e[16:0]});
            check({nm, "_sb_ovf"}, {31'd0, o}, {31'd0, e[17]});
        end
    endtask

    always @(negedge clk) begin
        if (done81)  score(0, {8'd0, sum81}, ovf81);
        if (done84)  score(1, {8'd0, sum84}, ovf84);
        if (done162) score(2, sum162, ovf162);
    end

    // Waits for done on instance sel; optionally checks sum holds its old value meanwhile.
    task automatic wait_done(input int sel, input logic hold_chk, input logic [16:0] prev,
                             output int at);
        logic seen = 1'b0;
        at = -1;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (done_of(sel)) begin
                seen = 1'b1;
                at   = cyc;
            end else if (hold_chk) begin
                check("sum_hold", {15'd0, sum_of(sel)}, {15'd0, prev});
            end
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input int sel, input logic [15:0] av, input logic [15:0] bv,
                          input logic md, input int nlat);
        int          t0, at;
        logic [16:0] prev;
        @(negedge clk);
        a = av;
        b = bv;
        mode = md;
        start[sel] = 1'b1;
        push(sel, av, bv, md);
        prev = sum_of(sel);
        @(posedge clk);
        #1;
        start[sel] = 1'b0;
        t0 = cyc;
        check("busy_after_start", {31'd0, busy_of(sel)}, 32'd1);
        wait_done(sel, 1'b1, prev, at);
        check("latency", at - t0, nlat);
    endtask

    initial begin
        int          t0, at, prev_at, seen;
        logic [15:0] av, bv;
        logic        md;

        rst_n = 1'b0;
        start = 3'b000;
        mode  = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        check("rst_sum81", {23'd0, sum81}, 32'd0);
        check("rst_busy81", {31'd0, busy81}, 32'd0);
        check("rst_done81", {31'd0, done81}, 32'd0);
        check("rst_ovf81", {31'd0, ovf81}, 32'd0);
        check("rst_sum162", {15'd0, sum162}, 32'd0);
        check("rst_busy162", {31'd0, busy162}, 32'd0);
        rst_n = 1'b1;

        // Directed W=8, D=1 cases
        run_op(0, 16'd143, 16'd57, 1'b0, 8);
        check("t1_sum", {23'd0, sum81}, 32'd200);
        check("t1_ovf", {31'd0, ovf81}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_done_one_cycle", {31'd0, done81}, 32'd0);
        check("t1_busy_idle", {31'd0, busy81}, 32'd0);

        run_op(0, 16'd200, 16'd100, 1'b0, 8);
        check("t2_sum_carry", {23'd0, sum81}, 32'd300);
        run_op(0, 16'd67, 16'd33, 1'b1, 8);
        check("t2_sub_sum", {23'd0, sum81}, 32'd34);

        run_op(0, 16'd33, 16'd67, 1'b1, 8);
        check("t3_sub_low", {24'd0, sum81[7:0]}, 32'd222);
        check("t3_borrow", {31'd0, sum81[8]}, 32'd1);
        run_op(0, 16'd100, 16'd100, 1'b0, 8);
        check("t3_ovf", {31'd0, ovf81}, 32'd1);
        check("t3_ovf_sum", {23'd0, sum81}, 32'd200);

        // W=8, D=4 single op, then START held high
        run_op(1, 16'd143, 16'd57, 1'b0, 2);
        check("t4_sum", {23'd0, sum84}, 32'd200);
        @(negedge clk);
        a = 16'd100;
        b = 16'd27;
        mode = 1'b1;
        start[1] = 1'b1;
        for (int i = 0; i < 4; i++) push(1, 16'd100, 16'd27, 1'b1);
        @(posedge clk);
        #1;
        t0 = cyc;
        prev_at = t0;
        for (int i = 0; i < 4; i++) begin
            wait_done(1, 1'b0, 17'd0, at);
            if (i == 3) start[1] = 1'b0;
            check(i == 0 ? "t4_first_latency" : "t4_period", at - prev_at, i == 0 ? 2 : 3);
            prev_at = at;
        end
        repeat (6) @(negedge clk);
        check("t4_b2b_sum", {23'd0, sum84}, 32'd73);
        check("t4_b2b_idle", {31'd0, busy84}, 32'd0);

        // START re-pulsed while busy is ignored
        @(negedge clk);
        a = 16'd10;
        b = 16'd20;
        mode = 1'b0;
        start[0] = 1'b1;
        push(0, 16'd10, 16'd20, 1'b0);
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        t0 = cyc;
        @(negedge clk);
        @(negedge clk);
        a = 16'd99;
        b = 16'd99;
        mode = 1'b1;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        wait_done(0, 1'b1, 17'd200, at);
        check("t5_ignore_latency", at - t0, 8);
        check("t5_ignore_sum", {23'd0, sum81}, 32'd30);
        repeat (3) @(negedge clk);
        check("t5_no_retrigger", {31'd0, busy81}, 32'd0);

        // Reset in the middle of an operation aborts it
        @(negedge clk);
        a = 16'd50;
        b = 16'd60;
        mode = 1'b0;
        start[0] = 1'b1;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_abort_sum", {23'd0, sum81}, 32'd0);
        check("t5_abort_busy", {31'd0, busy81}, 32'd0);
        check("t5_abort_done", {31'd0, done81}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done81) seen++;
        end
        check("t5_abort_no_done", seen, 0);
        check("t5_abort_sum_after", {23'd0, sum81}, 32'd0);

        // W=16, D=2: corners then random, both modes
        for (int i = 0; i < 200; i++) begin
            case (i)
                0:       begin av = 16'h7fff; bv = 16'h0001; md = 1'b0; end
                1:       begin av = 16'h8000; bv = 16'h0001; md = 1'b1; end
                2:       begin av = 16'hffff; bv = 16'h0001; md = 1'b0; end
                3:       begin av = 16'h0000; bv = 16'h8000; md = 1'b1; end
                default: begin
                    av = 16'($urandom);
                    bv = 16'($urandom);
                    md = 1'($urandom_range(0, 1));
                end
            endcase
            run_op(2, av, bv, md, 8);
        end
        repeat (3) @(negedge clk);

        for (int s = 0; s < 3; s++) check("done_count", done_cnt[s], accepted[s]);
        check("q0_empty", exp_q0.size(), 0);
        check("q1_empty", exp_q1.size(), 0);
        check("q2_empty", exp_q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
